csa_resolver: RTL
=================

# csa_resolver

Multi-cycle carry-propagate resolver that converts a carry-save pair (sum vector plus carry vector, carry bit i weighted 2^(i+1)) into an exact binary result. It sits downstream of the carry-save compression tree in the Booth/Wallace multiplier datapath and consumes its S/C pair. It trades latency for area by resolving CHUNK bits per cycle with a registered carry. Valid/ready handshakes are used on both sides.

## Interface
- WIDTH, 32: width of each carry-save input vector; must be a multiple of CHUNK.
- CHUNK, 8: bits resolved per cycle; 1 ≤ CHUNK ≤ WIDTH.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  S/C pair presented.
- in_ready  output  1  block can accept a pair.
- s_in  input  WIDTH  sum vector, bit i weight 2^i.
- c_in  input  WIDTH  carry vector, bit i weight 2^(i+1).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH+2  exact value s_in + 2·c_in.

## Operation
- NCHUNK = WIDTH/CHUNK. FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch A=s_in and B={c_in[WIDTH-2:0],1'b0}, and latch c_msb=c_in[WIDTH-1].
  - Clear the carry register and chunk index k. Go to RUN.
- RUN, one chunk per cycle:
  - {cy', result[k·CHUNK +: CHUNK]} = A_k + B_k + cy.
  - Increment k.
  - After chunk NCHUNK-1 is written, go to DONE.
- Entry to DONE:
  - result[WIDTH] = c_msb ^ cy.
  - result[WIDTH+1] = c_msb & cy.
- DONE:
  - out_valid=1 and result is stable.
  - On out_ready, go to IDLE.
- in_ready is 0 in RUN and DONE. Inputs are ignored there even if in_valid=1.
- result holds its last value after leaving DONE. It is meaningful only while out_valid=1.
- Arithmetic is exact: maximum value 3·(2^WIDTH−1) fits in WIDTH+2 bits, with no truncation or overflow flag.
- Reset (any state, including mid-RUN or DONE):
  - State goes to IDLE.
  - in_ready=1 in the cycle after the reset edge.
  - out_valid=0, result=0, carry=0, k=0.
  - Any in-flight operation is discarded.
- Illegal parameters (WIDTH % CHUNK ≠ 0, CHUNK = 0) are rejected at elaboration.

## Timing
- Acceptance edge T0. RUN occupies edges T1..T_NCHUNK.
- out_valid rises after edge T_NCHUNK, i.e. NCHUNK cycles after acceptance.
- Throughput: one result per NCHUNK+2 cycles with out_ready held high (accept, NCHUNK RUN cycles, DONE handshake cycle, IDLE).
- out_valid/result are held indefinitely under backpressure (out_ready=0).
- in_ready and out_valid are registered state decodes with no combinational path from in_valid or out_ready.
- CHUNK=WIDTH degenerates to one RUN cycle and is legal.

## Structure
- Shared package csa_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - a function computing NCHUNK and the index width $clog2(NCHUNK) (minimum 1 bit).
- One sub-module, csa_chunk_adder: a combinational CHUNK-bit adder with carry in and carry out, instantiated once and time-multiplexed by k.
- Operand selection is an indexed part-select of the A/B registers.

## Test plan
- WIDTH=8, CHUNK=4, s_in=0x0F, c_in=0x01 → result=0x011 (17) with out_valid exactly 2 cycles after acceptance.
- WIDTH=8, CHUNK=4, s_in=0xFF, c_in=0xFF → result=0x2FD (765); cross-chunk carry and both top bits exercised.
- s_in=0x80, c_in=0x80, WIDTH=8, CHUNK=2 → result=0x180; out_ready held low 10 cycles, so out_valid and result stay stable and in_ready stays 0 while in_valid is held high.
- Assert rst mid-RUN (k=1) → next cycle out_valid=0, result=0, in_ready=1; a new pair s_in=0x03, c_in=0x02 then gives 0x007.
- Back-to-back: 200 random pairs with random in_valid/out_ready gaps, WIDTH=32, CHUNK=8 → every result equals s+2c in order, and no pair is lost or duplicated.
- CHUNK=WIDTH=16, s_in=0xFFFF, c_in=0x0001 → result=0x10001 after 1 RUN cycle.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared types and sizing helpers for the carry-save resolver.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } csa_state_e;

  function automatic int unsigned csa_nchunk(input int unsigned width,
                                             input int unsigned chunk);
    return (chunk == 0) ? 1 : width / chunk;
  endfunction

  // Chunk index width, never narrower than one bit.
  function automatic int unsigned csa_idx_w(input int unsigned width,
                                            input int unsigned chunk);
    int unsigned n;
    n = csa_nchunk(width, chunk);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/csa_chunk_adder.sv
// Combinational CHUNK-bit adder with carry in and carry out.
module csa_chunk_adder
  import csa_pkg::*;
#(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout
);

  always_comb begin
    {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
  end

endmodule

// File: rtl/csa_resolver.sv
// Resolves a carry-save S/C pair into s + 2*c, CHUNK bits per cycle,
// with valid/ready handshakes on input and output.
module csa_resolver
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] s_in,
  input  logic [WIDTH-1:0] c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] result
);

  localparam int unsigned NCHUNK = csa_nchunk(WIDTH, CHUNK);
  localparam int unsigned KW     = csa_idx_w(WIDTH, CHUNK);
  localparam int unsigned AW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if ((CHUNK == 0) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("csa_resolver: WIDTH must be a non-zero multiple of CHUNK");
  end

  csa_state_e       r_state;
  csa_state_e       w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cmsb;
  logic             r_cy;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_lo;
  logic [1:0]       r_hi;

  logic [AW-1:0]    w_base;
  logic [CHUNK-1:0] w_sum;
  logic             w_cout;
  logic             w_last;

  assign w_base = AW'(32'(r_k) * CHUNK);
  assign w_last = (r_k == KW'(NCHUNK - 1));

  csa_chunk_adder #(.CHUNK(CHUNK)) u_adder (
    .i_a    (r_a[w_base +: CHUNK]),
    .i_b    (r_b[w_base +: CHUNK]),
    .i_cin  (r_cy),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cmsb  <= 1'b0;
      r_cy    <= 1'b0;
      r_k     <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a    <= s_in;
            r_b    <= c_in << 1;
            r_cmsb <= c_in[WIDTH-1];
            r_cy   <= 1'b0;
            r_k    <= '0;
          end
        end
        RUN: begin
          r_lo[w_base +: CHUNK] <= w_sum;
          r_cy <= w_cout;
          r_k  <= r_k + KW'(1);
          // The shifted-out carry MSB joins the final carry to form the top two bits.
          if (w_last) begin
            r_hi <= {r_cmsb & w_cout, r_cmsb ^ w_cout};
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = {r_hi, r_lo};

endmodule
